// File: rtl/layer_lut_writer.sv
// layer_lut_writer: truth-table store for one LUT-based neuron layer.
// A full table of 2**INPUT_BITS entries is streamed in through the cfg_*
// handshake in ascending address order. Lookups on M0 are then served with
// one cycle of latency while the table is resident.
// Optional build macro: LUT_READBACK_EN adds a debug readback port
// (rb_req/rb_addr/rb_valid/rb_data) that works in every state.
module layer_lut_writer #(
  parameter int INPUT_BITS  = 6,
  parameter int OUTPUT_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [OUTPUT_BITS-1:0] cfg_data,
  output logic                   cfg_done,
  output logic                   table_loaded,
  input  logic                   in_valid,
  input  logic [INPUT_BITS-1:0]  M0,
  output logic                   out_valid,
  output logic [OUTPUT_BITS-1:0] M1
`ifdef LUT_READBACK_EN
  ,
  input  logic                   rb_req,
  input  logic [INPUT_BITS-1:0]  rb_addr,
  output logic                   rb_valid,
  output logic [OUTPUT_BITS-1:0] rb_data
`endif
);

  localparam int DEPTH = 2 ** INPUT_BITS;
  localparam logic [INPUT_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [INPUT_BITS-1:0]   count_q, count_d;
  logic                    write_en;
  logic                    load_done;
  logic                    out_valid_q;
  logic [OUTPUT_BITS-1:0]  m1_q;

  // Table contents survive reset; only a complete reload makes them usable.
  logic [OUTPUT_BITS-1:0]  mem_q [DEPTH];

  // State and write-address registers; reset abandons any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; a cfg_start always wins over a same-cycle entry.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    write_en  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      EMPTY: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          count_d = '0;
        end else if (cfg_valid) begin
          write_en = 1'b1;
          count_d  = count_q + INPUT_BITS'(1);
          if (count_q == LAST_ADDR) begin
            state_d   = READY;
            load_done = 1'b1;
          end
        end
      end
      READY: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        count_d = '0;
      end
    endcase
  end

  // Single write port into the distributed table.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[count_q] <= cfg_data;
    end
  end

  // Lookup pipeline: the state seen at the sampling edge decides whether a
  // request is served, so a lookup coinciding with cfg_start still issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else if (in_valid && (state_q == READY)) begin
      out_valid_q <= 1'b1;
      m1_q        <= mem_q[M0];
    end else begin
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end
  end

`ifdef LUT_READBACK_EN
  logic                   rb_valid_q;
  logic [OUTPUT_BITS-1:0] rb_data_q;

  // Debug readback of any entry, independent of the load state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else if (rb_req) begin
      rb_valid_q <= 1'b1;
      rb_data_q  <= mem_q[rb_addr];
    end else begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`endif

  assign cfg_ready    = (state_q == LOAD);
  assign cfg_done     = load_done;
  assign table_loaded = (state_q == READY);
  assign out_valid    = out_valid_q;
  assign M1           = m1_q;

endmodule
